alu_result_stage: RTL

//   Registered output stage directly downstream of the 32-bit bitwise/logic unit (OR/NOR etc.).

---
 rtl/alu_result_stage_pkg.sv | 20 ++
 rtl/alu_flag_gen.sv | 13 +
 rtl/alu_result_stage.sv | 113 +++++++++++
 3 files changed

// File: rtl/alu_result_stage_pkg.sv
// Shared definitions for the ALU result stage: default width, state encodings
// and the per-word flag bundle carried alongside the result.
package alu_result_stage_pkg;

   localparam int ALU_WIDTH = 32;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   typedef struct packed {
      logic carryout;
      logic overflow;
      logic zero;
      logic negative;
   } flags_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational zero/negative flag derivation for one WIDTH-bit result word.
module alu_flag_gen #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] word,
   output logic             zero,
   output logic             negative
);

   assign zero     = (word == '0);
   assign negative = word[WIDTH-1];

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage with a 2-entry skid buffer behind a valid/ready handshake.
// Optional ALU_RESULT_STATS_EN adds saturating accepted-word / overflow counters.
module alu_result_stage
   import alu_result_stage_pkg::*;
#(
   parameter int WIDTH  = ALU_WIDTH,
   parameter int STAT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_result,
   input  logic              in_carryout,
   input  logic              in_overflow,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_result,
   output logic              out_carryout,
   output logic              out_overflow,
   output logic              out_zero,
`ifdef ALU_RESULT_STATS_EN
   input  logic              stat_clr,
   output logic [STAT_W-1:0] stat_words,
   output logic [STAT_W-1:0] stat_ovf,
`endif
   output logic              out_negative
);

   state_t           state;
   logic [WIDTH-1:0] main_res, skid_res;
   flags_t           main_flg, skid_flg, in_flg;
   logic             in_zero, in_neg;
   logic             in_fire, out_fire;

   alu_flag_gen #(.WIDTH(WIDTH)) u_flag (
      .word     (in_result),
      .zero     (in_zero),
      .negative (in_neg)
   );

   assign in_flg = '{carryout: in_carryout, overflow: in_overflow,
                     zero: in_zero, negative: in_neg};

   // Handshake outputs decode from state only, so out_ready never reaches in_ready.
   assign in_ready  = (state != ST_FULL);
   assign out_valid = (state != ST_EMPTY);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   assign out_result   = main_res;
   assign out_carryout = main_flg.carryout;
   assign out_overflow = main_flg.overflow;
   assign out_zero     = main_flg.zero;
   assign out_negative = main_flg.negative;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_EMPTY;
         main_res <= '0;
         main_flg <= '0;
         skid_res <= '0;
         skid_flg <= '0;
      end else begin
         case (state)
            ST_EMPTY: if (in_fire) begin
               main_res <= in_result;
               main_flg <= in_flg;
               state    <= ST_ONE;
            end
            ST_ONE: begin
               if (in_fire && !out_fire) begin
                  skid_res <= in_result;
                  skid_flg <= in_flg;
                  state    <= ST_FULL;
               end else if (out_fire && !in_fire) begin
                  state    <= ST_EMPTY;
               end else if (in_fire && out_fire) begin
                  main_res <= in_result;
                  main_flg <= in_flg;
               end
            end
            ST_FULL: if (out_fire) begin
               main_res <= skid_res;
               main_flg <= skid_flg;
               state    <= ST_ONE;
            end
            default: state <= ST_EMPTY;
         endcase
      end
   end

`ifdef ALU_RESULT_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_words <= '0;
         stat_ovf   <= '0;
      end else if (stat_clr) begin
         stat_words <= '0;
         stat_ovf   <= '0;
      end else if (in_fire) begin
         if (stat_words != '1)
            stat_words <= stat_words + 1'b1;
         if (in_overflow && stat_ovf != '1)
            stat_ovf <= stat_ovf + 1'b1;
      end
   end
`else
   logic [31:0] unused_stat_w;
   assign unused_stat_w = STAT_W;
`endif

endmodule
